// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// Grants one pending word, holds it on Tx_DATA for the frame, returns ack or timeout err.
`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

module uart_tx_sched #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned WORD_LENGTH    = `WORD_LENGTH,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [N_REQ*WORD_LENGTH-1:0] data_i,
    output logic [N_REQ-1:0]             ack_o,
    output logic                         err_o,
    output logic [$clog2(N_REQ)-1:0]     grant_idx_o,
    output logic                         busy_o,
    output logic                         tx_rqst_o,
    output logic [WORD_LENGTH-1:0]       tx_data_o,
    input  logic                         tx_ready_i
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        DONE      = 3'd3,
        ABORT     = 3'd4
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_ptr;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [CNT_W-1:0]       tmo_next;
    logic                   tmo_hit;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    logic [WORD_LENGTH-1:0] win_data;

    // Search upward from last_ptr+1, wrapping, for the first pending request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(last_ptr) + i) % N_REQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Word mux for the winner; constant part-selects only.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_data = data_i[k*WORD_LENGTH +: WORD_LENGTH];
            end
        end
    end

    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign tmo_next = tmo_hit ? tmo_cnt : tmo_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_ptr    <= IDX_W'(N_REQ - 1);
            tmo_cnt     <= '0;
            ack_o       <= '0;
            err_o       <= 1'b0;
            grant_idx_o <= '0;
            busy_o      <= 1'b0;
            tx_rqst_o   <= 1'b0;
            tx_data_o   <= '0;
        end else begin
            ack_o <= '0;
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && win_found && tx_ready_i) begin
                        state       <= ISSUE;
                        busy_o      <= 1'b1;
                        tx_rqst_o   <= 1'b1;
                        tx_data_o   <= win_data;
                        grant_idx_o <= win_idx;
                        tmo_cnt     <= '0;
                    end
                end
                ISSUE: begin
                    // READY falling means the transmitter took the word and is in its start bit.
                    if (!tx_ready_i) begin
                        state     <= WAIT_DONE;
                        tx_rqst_o <= 1'b0;
                        tmo_cnt   <= '0;
                    end else if (tmo_hit) begin
                        state     <= ABORT;
                        tx_rqst_o <= 1'b0;
                        err_o     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready_i) begin
                        state <= DONE;
                        ack_o <= N_REQ'(1) << grant_idx_o;
                    end else if (tmo_hit) begin
                        state <= ABORT;
                        err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                DONE, ABORT: begin
                    // A failed requester also drops to lowest priority.
                    last_ptr <= grant_idx_o;
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    tx_rqst_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a simple READY/BUSY transmitter model.
module tb_uart_tx_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned TMO  = 32;
    localparam int unsigned BUSY = 20;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] req_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0] ack_o;
    logic         err_o;
    logic [1:0]   grant_idx_o;
    logic         busy_o;
    logic         tx_rqst_o;
    logic [W-1:0] tx_data_o;
    logic         tx_ready_i;

    uart_tx_sched #(
        .N_REQ          (N),
        .WORD_LENGTH    (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .tx_rqst_o   (tx_rqst_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        int unsigned idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int          busy_cnt;
    bit          stuck;
    logic [W-1:0] cur_data;
    bit          prev_ack;
    int          rq_run;
    bit          rearm0;
    bit          rearm_now;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input bit is_err, input int unsigned idx, input logic [W-1:0] d);
        exp_t e;
        e.is_err = is_err;
        e.idx    = idx;
        e.data   = d;
        sb.push_back(e);
    endtask

    // One clock: scoreboard pops on ack/err, requester auto-clear, transmitter model.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (rearm_now) begin
            req_i[0]  = 1'b1;
            rearm_now = 1'b0;
        end
        if (prev_ack) begin
            check("busy_after_ack", 32'(busy_o), 32'd0);
            prev_ack = 1'b0;
        end
        if (ack_o != '0) begin
            prev_ack = 1'b1;
            check("ack_err_overlap", 32'(err_o), 32'd0);
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(ack_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_kind", 32'(e.is_err), 32'd0);
                check("ack_onehot", 32'(ack_o), 32'd1 << e.idx);
                check("ack_data", 32'(cur_data), 32'(e.data));
            end
            if (rearm0 && ack_o[0]) begin
                rearm0    = 1'b0;
                rearm_now = 1'b1;
            end
            req_i = req_i & ~ack_o;
        end
        if (err_o) begin
            if (sb.size() == 0) begin
                check("err_unexpected", 32'(err_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("err_kind", 32'(e.is_err), 32'd1);
                check("err_idx", 32'(grant_idx_o), e.idx);
                check("err_data", 32'(tx_data_o), 32'(e.data));
            end
            check("err_rqst_low", 32'(tx_rqst_o), 32'd0);
            check("err_rqst_len", 32'(rq_run), TMO);
            stuck = 1'b0;
        end
        rq_run = tx_rqst_o ? rq_run + 1 : 0;
        if (rst) begin
            busy_cnt   = 0;
            tx_ready_i = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                check("data_hold", 32'(tx_data_o), 32'(cur_data));
                tx_ready_i = 1'b1;
            end
        end else if (!stuck && tx_rqst_o && tx_ready_i) begin
            tx_ready_i = 1'b0;
            busy_cnt   = BUSY;
            cur_data   = tx_data_o;
        end
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy_o) && t < budget) begin
            step();
            t++;
        end
        check("drain_in_budget", 32'(t < budget), 32'd1);
        if (t >= budget) sb.delete();
    endtask

    task automatic wait_wait_done(input int budget);
        int t;
        t = 0;
        while (!(busy_o && !tx_rqst_o && !tx_ready_i) && t < budget) begin
            step();
            t++;
        end
        check("reach_wait_done", 32'(t < budget), 32'd1);
    endtask

    task automatic do_reset();
        req_i     = '0;
        rearm0    = 1'b0;
        rearm_now = 1'b0;
        stuck     = 1'b0;
        prev_ack  = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst    = 1'b0;
        rq_run = 0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        req_i      = '0;
        tx_ready_i = 1'b1;
        data_i     = {8'h44, 8'h33, 8'h22, 8'h11};
        busy_cnt   = 0;
        stuck      = 1'b0;
        cur_data   = '0;
        prev_ack   = 1'b0;
        rq_run     = 0;
        rearm0     = 1'b0;
        rearm_now  = 1'b0;

        step();
        check("rst_rqst", 32'(tx_rqst_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_grant", 32'(grant_idx_o), 32'd0);
        rst = 1'b0;
        step();

        // Single request
        data_i[7:0] = 8'hA5;
        push(1'b0, 0, 8'hA5);
        req_i = 4'b0001;
        check("rqst_before_grant", 32'(tx_rqst_o), 32'd0);
        step();
        check("grant_latency", 32'(tx_rqst_o), 32'd1);
        check("issue_data", 32'(tx_data_o), 32'hA5);
        check("issue_grant", 32'(grant_idx_o), 32'd0);
        drain(200);
        data_i[7:0] = 8'h11;

        // Fairness, with requester 0 re-asserting after its ack
        do_reset();
        push(1'b0, 0, 8'h11);
        push(1'b0, 1, 8'h22);
        push(1'b0, 2, 8'h33);
        push(1'b0, 3, 8'h44);
        push(1'b0, 0, 8'h11);
        rearm0 = 1'b1;
        req_i  = 4'b1111;
        drain(1000);

        // Wrap-around from last_ptr=2
        do_reset();
        push(1'b0, 2, 8'h33);
        req_i = 4'b0100;
        drain(200);
        push(1'b0, 3, 8'h44);
        push(1'b0, 0, 8'h11);
        req_i = 4'b1001;
        drain(400);

        // Timeout in ISSUE, then requester 1 ahead of the failed requester 0
        do_reset();
        stuck = 1'b1;
        push(1'b1, 0, 8'h11);
        push(1'b0, 1, 8'h22);
        push(1'b0, 0, 8'h11);
        req_i = 4'b0011;
        drain(1000);

        // Reset mid-frame
        do_reset();
        req_i = 4'b0001;
        wait_wait_done(50);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rqst", 32'(tx_rqst_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_data", 32'(tx_data_o), 32'd0);
        check("midrst_grant", 32'(grant_idx_o), 32'd0);
        check("midrst_ack", 32'(ack_o), 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        req_i    = '0;
        prev_ack = 1'b0;
        step();
        rst = 1'b0;
        push(1'b0, 1, 8'h22);
        req_i = 4'b0010;
        drain(200);

        // Enable gating
        do_reset();
        en    = 1'b0;
        req_i = 4'b1111;
        repeat (10) step();
        check("en_low_busy", 32'(busy_o), 32'd0);
        check("en_low_rqst", 32'(tx_rqst_o), 32'd0);
        en = 1'b1;
        push(1'b0, 0, 8'h11);
        wait_wait_done(50);
        en = 1'b0;
        drain(200);
        repeat (10) step();
        check("en_low_after_ack", 32'(busy_o), 32'd0);
        check("en_low_pending", 32'(req_i), 32'b1110);
        en = 1'b1;
        push(1'b0, 1, 8'h22);
        push(1'b0, 2, 8'h33);
        push(1'b0, 3, 8'h44);
        drain(1000);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
